// File: rtl/uart_reg_bank_pkg.sv
// Shared constants for the UART register bank: register indices and bit positions.
// The optional interrupt logic is enabled with the UART_REG_IRQ_EN macro.
package uart_reg_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_OVERRUN  = 4;

  localparam int CTRL_OVR_CLR = 16;
  localparam int CTRL_FLUSH   = 17;
  localparam int CTRL_RX_IE   = 18;
  localparam int CTRL_TX_IE   = 19;

  localparam int DVSR_W = 11;

  // Only address bits [3:2] select a register; everything else is ignored.
  function automatic reg_sel_e addr_sel(input logic [1:0] word_idx);
    return reg_sel_e'(word_idx);
  endfunction

endpackage

// File: rtl/uart_reg_bank_fifo.sv
// Synchronous first-word-fall-through FIFO with (AW+1)-bit wrapping pointers.
// dout shows the head entry, or zero while empty.
module reg_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Pop on empty is dropped; a pop on full frees the slot for a same-cycle push.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_reg_bank.sv
// UART register bank: 4-word register map, TX/RX byte FIFOs and baud divisor.
// Define UART_REG_IRQ_EN to add the irq output and the CTRL interrupt enables.
module uart_reg_bank
  import uart_reg_pkg::*;
#(
  parameter int             ADDR_WIDTH = 32,
  parameter int             DATA_WIDTH = 32,
  parameter int             FIFO_AW    = 4,
  parameter logic [10:0]    DVSR_RST   = 11'd650
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            wr_strb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
`ifdef UART_REG_IRQ_EN
  output logic                  irq,
`endif
  output logic [10:0]           dvsr
);

  reg_sel_e wr_sel, rd_sel;
  logic [3:0]  strb_q, strb_d;
  logic [10:0] dvsr_q, dvsr_d;
  logic        ovr_q, ovr_d;

  logic ctrl_wr, ctrl_hi, flush, ovr_clr, ovr_set;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  assign wr_sel = addr_sel(wr_addr[3:2]);
  assign rd_sel = addr_sel(rd_addr[3:2]);

  assign ctrl_wr = wr_valid && (wr_sel == REG_CTRL);
  assign ctrl_hi = ctrl_wr && strb_q[2];
  assign flush   = ctrl_hi && wr_data[CTRL_FLUSH];
  assign ovr_clr = ctrl_hi && wr_data[CTRL_OVR_CLR];

  assign tx_push = wr_valid && (wr_sel == REG_TXDATA) && strb_q[0];
  assign rx_pop  = rd_valid && (rd_sel == REG_RXDATA);
  // A byte is lost only when the RX FIFO is full and nobody pops this cycle.
  assign ovr_set = rx_valid && rx_full && !rx_pop;

  // tx_valid/tx_ready: a byte moves to the transmitter on every cycle where
  // both are high; tx_data stays stable while tx_valid is high and tx_ready low.
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  reg_fifo #(.DW(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (wr_data[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  reg_fifo #(.DW(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (rx_pop),
    .flush (flush),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // The strobe latch holds the byte enables seen ahead of the commit pulse.
  always_comb begin
    strb_d = strb_q;
    if (wr_strb != 4'b0000)  strb_d = wr_strb;
    else if (wr_valid)       strb_d = 4'b0000;

    dvsr_d = dvsr_q;
    if (ctrl_wr && strb_q[0]) dvsr_d[7:0]  = wr_data[7:0];
    if (ctrl_wr && strb_q[1]) dvsr_d[10:8] = wr_data[10:8];

    ovr_d = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strb_q <= 4'b0000;
      dvsr_q <= DVSR_RST;
      ovr_q  <= 1'b0;
    end else begin
      strb_q <= strb_d;
      dvsr_q <= dvsr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign dvsr = dvsr_q;

`ifdef UART_REG_IRQ_EN
  logic rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;

  always_comb begin
    rx_ie_d = rx_ie_q;
    tx_ie_d = tx_ie_q;
    if (ctrl_hi) begin
      rx_ie_d = wr_data[CTRL_RX_IE];
      tx_ie_d = wr_data[CTRL_TX_IE];
    end
    irq_d = (rx_ie_q && !rx_empty) || (tx_ie_q && tx_empty) || ovr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rx_ie_q <= rx_ie_d;
      tx_ie_q <= tx_ie_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      REG_RXDATA: begin
        rd_data[8]   = rx_empty;
        rd_data[7:0] = rx_head;
      end
      REG_STATUS: begin
        rd_data[ST_TX_EMPTY] = tx_empty;
        rd_data[ST_TX_FULL]  = tx_full;
        rd_data[ST_RX_EMPTY] = rx_empty;
        rd_data[ST_RX_FULL]  = rx_full;
        rd_data[ST_OVERRUN]  = ovr_q;
      end
      REG_CTRL: begin
        rd_data[DVSR_W-1:0] = dvsr_q;
`ifdef UART_REG_IRQ_EN
        rd_data[CTRL_RX_IE] = rx_ie_q;
        rd_data[CTRL_TX_IE] = tx_ie_q;
`endif
      end
      default: rd_data = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{wr_addr, rd_addr, wr_data};

endmodule

// File: tb/tb_uart_reg_bank.sv
// Self-checking bench for uart_reg_bank: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_reg_bank;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wr_strb;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic        wr_valid, rd_valid;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;
  logic [10:0] dvsr;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifndef UART_REG_IRQ_EN
  assign irq = 1'b0;
`endif

  uart_reg_bank dut (
    .clk      (clk),
    .reset    (reset),
    .wr_strb  (wr_strb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`ifdef UART_REG_IRQ_EN
    .irq      (irq),
`endif
    .dvsr     (dvsr)
  );

  // ---------------- reference model ----------------
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_exp_q[$];
  logic        m_ovr, m_rx_ie, m_tx_ie, m_irq, model_live = 1'b0;
  logic [10:0] m_dvsr;
  logic [3:0]  m_strb;
  logic        m_cw, m_flush, m_clr, m_rxp, m_set, m_irq_nx;

  always @(posedge clk) begin
    if (reset) begin
      tx_exp_q.delete();
      rx_exp_q.delete();
      m_ovr = 0; m_rx_ie = 0; m_tx_ie = 0; m_irq = 0;
      m_dvsr = 11'd650; m_strb = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_irq_nx = (m_rx_ie && rx_exp_q.size() != 0) || (m_tx_ie && tx_exp_q.size() == 0) || m_ovr;
      m_cw    = wr_valid && (wr_addr[3:2] == 2'd3);
      m_flush = m_cw && m_strb[2] && wr_data[17];
      m_clr   = m_cw && m_strb[2] && wr_data[16];
      m_rxp   = rd_valid && (rd_addr[3:2] == 2'd1);
      m_set   = rx_valid && rx_exp_q.size() == DEPTH && !m_rxp;
      if (m_flush) begin
        tx_exp_q.delete();
        rx_exp_q.delete();
      end else begin
        if (tx_ready && tx_exp_q.size() != 0) void'(tx_exp_q.pop_front());
        if (m_rxp && rx_exp_q.size() != 0) void'(rx_exp_q.pop_front());
        if (wr_valid && wr_addr[3:2] == 2'd0 && m_strb[0] && tx_exp_q.size() < DEPTH)
          tx_exp_q.push_back(wr_data[7:0]);
        if (rx_valid && rx_exp_q.size() < DEPTH) rx_exp_q.push_back(rx_data);
      end
      if (m_set) m_ovr = 1;
      else if (m_clr) m_ovr = 0;
      if (m_cw && m_strb[0]) m_dvsr[7:0] = wr_data[7:0];
      if (m_cw && m_strb[1]) m_dvsr[10:8] = wr_data[10:8];
`ifdef UART_REG_IRQ_EN
      if (m_cw && m_strb[2]) begin
        m_rx_ie = wr_data[18];
        m_tx_ie = wr_data[19];
      end
      m_irq = m_irq_nx;
`endif
      if (wr_strb != 0) m_strb = wr_strb;
      else if (wr_valid) m_strb = 0;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a[3:2])
      2'd1: r = {23'b0, rx_exp_q.size() == 0, (rx_exp_q.size() != 0) ? rx_exp_q[0] : 8'h00};
      2'd2: r = {27'b0, m_ovr, rx_exp_q.size() == DEPTH, rx_exp_q.size() == 0,
                 tx_exp_q.size() == DEPTH, tx_exp_q.size() == 0};
      2'd3: begin
        r[10:0] = m_dvsr;
`ifdef UART_REG_IRQ_EN
        r[18] = m_rx_ie;
        r[19] = m_tx_ie;
`endif
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live && !reset) begin
      chk("cyc_tx_valid", {31'b0, tx_valid}, {31'b0, tx_exp_q.size() != 0});
      chk("cyc_tx_data", {24'b0, tx_data}, {24'b0, (tx_exp_q.size() != 0) ? tx_exp_q[0] : 8'h00});
      chk("cyc_dvsr", {21'b0, dvsr}, {21'b0, m_dvsr});
      chk("cyc_rd_data", rd_data, exp_rd(rd_addr));
      chk("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    wr_valid = 0; rd_valid = 0; rx_valid = 0; wr_strb = 0;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wr_addr = addr; wr_data = data; wr_strb = strb;
    tick();
    wr_valid = 1;
    tick();
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    @(negedge clk);
    chk(name, rd_data, exp);
    rd_valid = 1;
    tick();
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] txb [17];
  int         wphase;
  logic       found;

  initial begin
    reset = 1; wr_strb = 0; wr_addr = 0; wr_data = 0; wr_valid = 0;
    rd_addr = 0; rd_valid = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    read_chk("reset_status", 32'h8, 32'h0000_0005);
    read_chk("reset_ctrl", 32'hC, 32'h0000_028A);

    write(32'h0, 32'h41, 4'b0001);
    @(negedge clk);
    chk("tx_valid_after_write", {31'b0, tx_valid}, 32'h1);
    chk("tx_data_after_write", {24'b0, tx_data}, 32'h41);
    tx_ready = 1;
    tick();
    tx_ready = 0;
    @(negedge clk);
    chk("tx_valid_after_pop", {31'b0, tx_valid}, 32'h0);

    for (int i = 0; i < 16; i++) rx_push(8'(i));
    rx_push(8'hAA);
    read_chk("status_overrun", 32'h8, 32'h0000_0019);
    for (int i = 0; i < 16; i++) read_chk("rx_order", 32'h4, 32'(i));
    read_chk("rx_empty_read", 32'h4, 32'h0000_0100);
    write(32'hC, 32'h0001_0000, 4'b0100);
    read_chk("overrun_w1c", 32'h8, 32'h0000_0005);

    for (int i = 0; i < 16; i++) begin
      txb[i] = 8'($urandom);
      write(32'h0, {24'b0, txb[i]}, 4'b0001);
    end
    read_chk("status_tx_full", 32'h8, 32'h0000_0006);
    txb[16] = 8'($urandom);
    write(32'h0, {24'b0, txb[16]}, 4'b0001);
    tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tx_drain_valid", {31'b0, tx_valid}, 32'h1);
      chk("tx_drain_data", {24'b0, tx_data}, {24'b0, txb[i]});
      @(posedge clk);
      #1;
    end
    tx_ready = 0;
    @(negedge clk);
    chk("tx_drain_done", {31'b0, tx_valid}, 32'h0);

    for (int i = 0; i < 16; i++) rx_push(8'(8'h80 + i));
    rx_data = 8'h5A; rx_valid = 1; rd_addr = 32'h4;
    @(negedge clk);
    chk("rx_full_head", rd_data, 32'h80);
    rd_valid = 1;
    tick();
    read_chk("status_full_concurrent", 32'h8, 32'h0000_0009);
    for (int i = 1; i < 16; i++) read_chk("rx_shifted", 32'h4, 32'(8'h80 + i));
    read_chk("rx_new_tail", 32'h4, 32'h5A);
    read_chk("rx_drained", 32'h4, 32'h0000_0100);

    rx_push(8'h11); rx_push(8'h22);
    write(32'h0, 32'h33, 4'b0001);
    read_chk("status_pre_flush", 32'h8, 32'h0000_0000);
    write(32'hC, 32'h0002_0000, 4'b0100);
    read_chk("status_flush", 32'h8, 32'h0000_0005);

    write(32'hC, 32'h0000_0123, 4'b0011);
    read_chk("dvsr_full_write", 32'hC, 32'h0000_0123);
    write(32'hFFFF_FFFC, 32'h0000_07FF, 4'b0001);
    read_chk("dvsr_lane0_alias", 32'hC, 32'h0000_01FF);
    write(32'hC, 32'h0000_0400, 4'b0010);
    read_chk("dvsr_lane1", 32'h1234_567F, 32'h0000_04FF);
    write(32'h8, 32'hFFFF_FFFF, 4'b1111);
    read_chk("status_write_ignored", 32'h1234_567B, 32'h0000_0005);

`ifdef UART_REG_IRQ_EN
    write(32'hC, 32'h0004_0000, 4'b0100);
    read_chk("ctrl_rx_ie", 32'hC, 32'h0004_04FF);
    rx_push(8'h33);
    found = 0;
    for (int k = 0; k < 2 && !found; k++) begin
      @(negedge clk);
      if (irq) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("irq_rise", {31'b0, found}, 32'h1);
    read_chk("irq_rx_byte", 32'h4, 32'h33);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("irq_fall", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rx_push(8'(i));
      write(32'h0, 32'(i), 4'b0001);
    end
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("irq_after_reset", {31'b0, irq}, 32'h0);
    read_chk("status_after_reset", 32'h8, 32'h0000_0005);
`endif

    wphase = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      if (wphase == 1) begin
        wr_valid = 1;
        wphase = 0;
      end else if ($urandom_range(0, 9) < 3) begin
        wr_addr = $urandom;
        wr_strb = 4'($urandom_range(1, 15));
        wr_data = $urandom;
        if ($urandom_range(0, 15) != 0) wr_data[17] = 1'b0;
        wphase = 1;
      end
      rx_data  = 8'($urandom);
      rx_valid = (n < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
      rd_addr  = $urandom;
      rd_valid = ($urandom_range(0, 3) == 0);
      tx_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
